// File: rtl/equ_sched_pkg.sv
// Shared definitions for the per-symbol equalizer scheduler.
// Contents:
//   default slot geometry, symbol-index width, FSM state enum, and
//   next_data_idx(), the data-symbol index advance that steps over the pilot.
package equ_sched_pkg;

  localparam int unsigned SYMS_PER_SLOT_DEF = 7;
  localparam int unsigned PILOT_SYM_DEF     = 3;
  localparam int unsigned SLOT_W_DEF        = 4;
  localparam int unsigned TIMEOUT_CYC_DEF   = 1024;
  localparam int unsigned IDX_W             = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ_P = 3'd1,
    ST_EST   = 3'd2,
    ST_REQ_D = 3'd3,
    ST_EQU   = 3'd4
  } state_t;

  // One extra bit so that running past the last symbol of the slot is visible.
  function automatic logic [IDX_W:0] next_data_idx(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] pilot);
    logic [IDX_W:0] nxt;
    nxt = {1'b0, idx} + (IDX_W+1)'(1);
    if (nxt == {1'b0, pilot}) begin
      nxt = nxt + (IDX_W+1)'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/equ_sym_sched.sv
// Sequencer for the per-symbol register between the resource demapper and the
// equalizer / channel estimator. Per slot it fetches the DMRS symbol and runs
// channel estimation, then fetches each data symbol in order (skipping the
// pilot) and runs the equalizer on it, repeating for the programmed slot count.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start             start pulse, honoured in IDLE only
//   i_num_slots         slots per transfer, sampled with i_start (0 means 1)
//   o_rdm_req/o_rdm_idx demapper symbol request and index
//   i_rdm_valid         demapper data for o_rdm_idx present this cycle
//   o_wen, o_pilot      register write enable / DMRS flag (combinational)
//   o_est_start         1-cycle pulse, start channel estimation
//   i_est_done          estimator finished
//   o_equ_start         1-cycle pulse, equalize current data symbol
//   i_equ_done          equalizer finished
//   o_busy              not IDLE
//   o_slot_done         1-cycle pulse at end of each slot
//   o_done              1-cycle pulse at end of the transfer
//   o_timeout           1-cycle watchdog pulse
//
// Build option: EQU_SCHED_TIMEOUT_EN enables a per-state watchdog of
// TIMEOUT_CYC cycles that aborts to IDLE; without it o_timeout is tied 0.
module equ_sym_sched
  import equ_sched_pkg::*;
#(
  parameter int unsigned SYMS_PER_SLOT = SYMS_PER_SLOT_DEF,
  parameter int unsigned PILOT_SYM     = PILOT_SYM_DEF,
  parameter int unsigned SLOT_W        = SLOT_W_DEF,
  parameter int unsigned TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [SLOT_W-1:0] i_num_slots,
  output logic              o_rdm_req,
  output logic [IDX_W-1:0]  o_rdm_idx,
  input  logic              i_rdm_valid,
  output logic              o_wen,
  output logic              o_pilot,
  output logic              o_est_start,
  input  logic              i_est_done,
  output logic              o_equ_start,
  input  logic              i_equ_done,
  output logic              o_busy,
  output logic              o_slot_done,
  output logic              o_done,
  output logic              o_timeout
);

  localparam logic [IDX_W-1:0] PILOT_IDX  = IDX_W'(PILOT_SYM);
  localparam logic [IDX_W-1:0] FIRST_DATA = (PILOT_SYM == 0) ? IDX_W'(1) : IDX_W'(0);
  localparam logic [IDX_W:0]   SYM_LIM    = (IDX_W+1)'(SYMS_PER_SLOT);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  sym_q, sym_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] nslots_q, nslots_d;
  logic [SLOT_W-1:0] slot_inc;
  logic [IDX_W:0]    nxt_idx;
  logic              est_start_q, est_start_d;
  logic              equ_start_q, equ_start_d;
  logic              slot_done_q, slot_done_d;
  logic              done_q, done_d;

`ifdef EQU_SCHED_TIMEOUT_EN
  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    slot_d      = slot_q;
    nslots_d    = nslots_q;
    est_start_d = 1'b0;
    equ_start_d = 1'b0;
    slot_done_d = 1'b0;
    done_d      = 1'b0;
    nxt_idx     = next_data_idx(sym_q, PILOT_IDX);
    slot_inc    = slot_q + SLOT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          nslots_d = (i_num_slots == '0) ? SLOT_W'(1) : i_num_slots;
          slot_d   = '0;
          sym_d    = '0;
          state_d  = ST_REQ_P;
        end
      end
      ST_REQ_P: begin
        if (i_rdm_valid) begin
          est_start_d = 1'b1;
          state_d     = ST_EST;
        end
      end
      ST_EST: begin
        // Accepted from the first EST cycle, so a same-cycle done is not lost.
        if (i_est_done) begin
          sym_d   = FIRST_DATA;
          state_d = ST_REQ_D;
        end
      end
      ST_REQ_D: begin
        if (i_rdm_valid) begin
          equ_start_d = 1'b1;
          state_d     = ST_EQU;
        end
      end
      ST_EQU: begin
        if (i_equ_done) begin
          if (nxt_idx < SYM_LIM) begin
            sym_d   = nxt_idx[IDX_W-1:0];
            state_d = ST_REQ_D;
          end else begin
            slot_done_d = 1'b1;
            slot_d      = slot_inc;
            sym_d       = '0;
            if (slot_inc == nslots_q) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_REQ_P;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef EQU_SCHED_TIMEOUT_EN
    // Watchdog fires only while the FSM is stuck; real progress wins a tie.
    timeout_d = 1'b0;
    if ((state_q != ST_IDLE) && (state_d == state_q) && (wd_q == WD_LAST)) begin
      state_d   = ST_IDLE;
      sym_d     = '0;
      slot_d    = '0;
      timeout_d = 1'b1;
    end
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif
  end

  // State, counters and registered pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sym_q       <= '0;
      slot_q      <= '0;
      nslots_q    <= '0;
      est_start_q <= 1'b0;
      equ_start_q <= 1'b0;
      slot_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      slot_q      <= slot_d;
      nslots_q    <= nslots_d;
      est_start_q <= est_start_d;
      equ_start_q <= equ_start_d;
      slot_done_q <= slot_done_d;
      done_q      <= done_d;
    end
  end

`ifdef EQU_SCHED_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYC);
  assign o_timeout      = 1'b0;
`endif

  // Request decode from state; write strobes follow demapper valid in the same cycle.
  assign o_rdm_req   = (state_q == ST_REQ_P) || (state_q == ST_REQ_D);
  assign o_rdm_idx   = (state_q == ST_REQ_P) ? PILOT_IDX :
                       (state_q == ST_REQ_D) ? sym_q     : '0;
  assign o_wen       = i_rdm_valid && o_rdm_req;
  assign o_pilot     = i_rdm_valid && (state_q == ST_REQ_P);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_est_start = est_start_q;
  assign o_equ_start = equ_start_q;
  assign o_slot_done = slot_done_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_equ_sym_sched.sv
// Directed bench for equ_sym_sched with default geometry (7 symbols, pilot 3).
// Peers: demapper answers combinationally; estimator/equalizer answer after a
// programmable latency. Extra stray pulses can be ORed onto the inputs.
module tb_equ_sym_sched;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [3:0] i_num_slots;
  logic       i_rdm_valid;
  logic       i_est_done;
  logic       i_equ_done;
  logic       o_rdm_req;
  logic [2:0] o_rdm_idx;
  logic       o_wen;
  logic       o_pilot;
  logic       o_est_start;
  logic       o_equ_start;
  logic       o_busy;
  logic       o_slot_done;
  logic       o_done;
  logic       o_timeout;

  logic start_drv = 1'b0;
  logic stray_en = 1'b0;
  logic stray_valid = 1'b0;
  logic stray_start = 1'b0;
  logic stray_est = 1'b0;
  logic stray_equ = 1'b0;
  logic peer_est_done = 1'b0;
  logic peer_equ_done = 1'b0;
  int   est_lat = 1;
  int   equ_lat = 1;
  int   est_cnt = 0;
  int   equ_cnt = 0;

  int   n_checks = 0;
  int   n_fail = 0;

  int   cyc = 0;
  int   wen_cnt = 0;
  int   pilot_cnt = 0;
  int   bad_wen_cnt = 0;
  int   slot_done_cnt = 0;
  int   done_cnt = 0;
  int   timeout_cnt = 0;
  int   est_start_cyc = 0;
  int   est_done_cyc = 0;
  int   first_req_cyc = 0;
  int   equ_start_cyc = 0;
  int   timeout_cyc = 0;
  logic waiting_req = 1'b0;
  logic [2:0] idx_log[$];
  logic       pil_log[$];

  always #5 i_clk = ~i_clk;

  assign i_rdm_valid = o_rdm_req | stray_valid;
  assign i_start     = start_drv | stray_start;
  assign i_est_done  = peer_est_done | stray_est;
  assign i_equ_done  = peer_equ_done | stray_equ;

  equ_sym_sched #(
    .SYMS_PER_SLOT(7),
    .PILOT_SYM(3),
    .SLOT_W(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_slots(i_num_slots),
    .o_rdm_req(o_rdm_req), .o_rdm_idx(o_rdm_idx), .i_rdm_valid(i_rdm_valid),
    .o_wen(o_wen), .o_pilot(o_pilot), .o_est_start(o_est_start), .i_est_done(i_est_done),
    .o_equ_start(o_equ_start), .i_equ_done(i_equ_done), .o_busy(o_busy),
    .o_slot_done(o_slot_done), .o_done(o_done), .o_timeout(o_timeout)
  );

  // Estimator / equalizer response models.
  always @(negedge i_clk) begin
    peer_est_done = 1'b0;
    peer_equ_done = 1'b0;
    if (est_cnt > 0) begin
      est_cnt--;
      if (est_cnt == 0) peer_est_done = 1'b1;
    end
    if (o_est_start) begin
      if (est_lat == 0) peer_est_done = 1'b1;
      else if (est_lat > 0) est_cnt = est_lat;
    end
    if (equ_cnt > 0) begin
      equ_cnt--;
      if (equ_cnt == 0) peer_equ_done = 1'b1;
    end
    if (o_equ_start) begin
      if (equ_lat == 0) peer_equ_done = 1'b1;
      else if (equ_lat > 0) equ_cnt = equ_lat;
    end
  end

  // Stray pulses; start only while busy so it can never launch a transfer.
  always @(negedge i_clk) begin
    stray_valid = stray_en && (cyc % 3 == 1);
    stray_start = stray_en && o_busy && (cyc % 4 == 0);
    stray_est   = stray_en && (cyc % 5 == 2);
    stray_equ   = stray_en && (cyc % 6 == 3);
  end

  // Event recorder.
  always @(negedge i_clk) begin
    #1;
    cyc++;
    if (o_wen) begin
      wen_cnt++;
      idx_log.push_back(o_rdm_idx);
      pil_log.push_back(o_pilot);
    end
    if (o_pilot) pilot_cnt++;
    if ((o_wen || o_pilot) && !o_rdm_req) bad_wen_cnt++;
    if (o_slot_done) slot_done_cnt++;
    if (o_done) done_cnt++;
    if (o_timeout) begin
      timeout_cnt++;
      timeout_cyc = cyc;
    end
    if (waiting_req && o_rdm_req) begin
      first_req_cyc = cyc;
      waiting_req   = 1'b0;
    end
    if (o_est_start) begin
      est_start_cyc = cyc;
      waiting_req   = 1'b1;
    end
    if (i_est_done) est_done_cyc = cyc;
    if (o_equ_start) equ_start_cyc = cyc;
  end

  task automatic step();
    @(negedge i_clk);
    #3;
  endtask

  function automatic logic [11:0] all_outs();
    return {o_rdm_req, o_wen, o_pilot, o_est_start, o_equ_start, o_busy,
            o_slot_done, o_done, o_timeout, o_rdm_idx};
  endfunction

  task automatic run_xfer(input logic [3:0] n, input int budget, input logic with_stray,
                          output int cycles, output logic timed_out, output int busy_gaps);
    cycles    = 0;
    timed_out = 1'b1;
    busy_gaps = 0;
    i_num_slots = n;
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    stray_en  = with_stray;
    while (cycles < budget) begin
      if (o_done) begin
        timed_out = 1'b0;
        break;
      end
      if (!o_busy) busy_gaps++;
      step();
      cycles++;
    end
    stray_en = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_num_slots = 4'd0;
    step();
    step();
    n_checks++;
    if (all_outs() !== 12'h000)
      $display("FAIL reset_hold: outputs got %h expected 000", all_outs());
    if (all_outs() !== 12'h000) n_fail++;
    i_rst = 1'b0;
    step();
    step();
    n_checks++;
    if (all_outs() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_idle: outputs got %h expected 000", all_outs());
    end
  endtask

  // One slot, 1-cycle peers; with_stray adds ignored/legal extra pulses.
  task automatic test_single(input string tag, input logic with_stray);
    int w0, p0, s0, d0, q0, b0, cycles, gaps;
    logic to;
    logic [2:0] exp_idx[7];
    exp_idx = '{3'd3, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    w0 = wen_cnt; p0 = pilot_cnt; s0 = slot_done_cnt; d0 = done_cnt;
    b0 = bad_wen_cnt; q0 = idx_log.size();
    est_lat = 1;
    equ_lat = 1;
    run_xfer(4'd1, 300, with_stray, cycles, to, gaps);
    step();
    n_checks++;
    if (to !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_wait: o_done not seen within budget", tag);
    end
    if (!with_stray) begin
      n_checks++;
      if (cycles !== 21) begin
        n_fail++;
        $display("FAIL %s_cycles: got %0d expected 21", tag, cycles);
      end
    end
    n_checks++;
    if (wen_cnt - w0 !== 7) begin
      n_fail++;
      $display("FAIL %s_wen: got %0d expected 7", tag, wen_cnt - w0);
    end
    n_checks++;
    if ((pilot_cnt - p0 !== 1) || (slot_done_cnt - s0 !== 1) || (done_cnt - d0 !== 1)) begin
      n_fail++;
      $display("FAIL %s_pulses: pilot %0d slot_done %0d done %0d expected 1 1 1",
               tag, pilot_cnt - p0, slot_done_cnt - s0, done_cnt - d0);
    end
    n_checks++;
    if (bad_wen_cnt - b0 !== 0) begin
      n_fail++;
      $display("FAIL %s_wen_no_req: got %0d expected 0", tag, bad_wen_cnt - b0);
    end
    if (idx_log.size() >= q0 + 7) begin
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if ((idx_log[q0+i] !== exp_idx[i]) || (pil_log[q0+i] !== (i == 0))) begin
          n_fail++;
          $display("FAIL %s_seq[%0d]: idx %0d pilot %0b expected idx %0d pilot %0b",
                   tag, i, idx_log[q0+i], pil_log[q0+i], exp_idx[i], (i == 0));
        end
      end
    end
  endtask

  task automatic test_zero_latency();
    int w0, cycles, gaps;
    logic to;
    w0 = wen_cnt;
    est_lat = 0;
    equ_lat = 0;
    run_xfer(4'd1, 300, 1'b0, cycles, to, gaps);
    step();
    n_checks++;
    if ((to !== 1'b0) || (cycles !== 14)) begin
      n_fail++;
      $display("FAIL zero_lat_cycles: got %0d timed_out %0b expected 14", cycles, to);
    end
    n_checks++;
    if (wen_cnt - w0 !== 7) begin
      n_fail++;
      $display("FAIL zero_lat_wen: got %0d expected 7", wen_cnt - w0);
    end
  endtask

  task automatic test_multi_slot();
    int w0, p0, s0, d0, cycles, gaps;
    logic to;
    w0 = wen_cnt; p0 = pilot_cnt; s0 = slot_done_cnt; d0 = done_cnt;
    est_lat = 1;
    equ_lat = 1;
    run_xfer(4'd3, 500, 1'b0, cycles, to, gaps);
    step();
    n_checks++;
    if ((to !== 1'b0) || (cycles !== 63)) begin
      n_fail++;
      $display("FAIL multi_cycles: got %0d timed_out %0b expected 63", cycles, to);
    end
    n_checks++;
    if ((wen_cnt - w0 !== 21) || (pilot_cnt - p0 !== 3)) begin
      n_fail++;
      $display("FAIL multi_wen: wen %0d pilot %0d expected 21 3", wen_cnt - w0, pilot_cnt - p0);
    end
    n_checks++;
    if ((slot_done_cnt - s0 !== 3) || (done_cnt - d0 !== 1)) begin
      n_fail++;
      $display("FAIL multi_pulses: slot_done %0d done %0d expected 3 1",
               slot_done_cnt - s0, done_cnt - d0);
    end
    n_checks++;
    if (gaps !== 0) begin
      n_fail++;
      $display("FAIL multi_busy: busy low %0d cycles expected 0", gaps);
    end
  endtask

  task automatic test_zero_slots();
    int w0, s0, d0, cycles, gaps;
    logic to;
    w0 = wen_cnt; s0 = slot_done_cnt; d0 = done_cnt;
    run_xfer(4'd0, 300, 1'b0, cycles, to, gaps);
    step();
    n_checks++;
    if ((to !== 1'b0) || (wen_cnt - w0 !== 7) || (slot_done_cnt - s0 !== 1) || (done_cnt - d0 !== 1)) begin
      n_fail++;
      $display("FAIL zero_slots: wen %0d slot_done %0d done %0d expected 7 1 1",
               wen_cnt - w0, slot_done_cnt - s0, done_cnt - d0);
    end
  endtask

  task automatic test_est_delay();
    int cycles, gaps;
    logic to;
    est_lat = 50;
    equ_lat = 1;
    run_xfer(4'd1, 400, 1'b0, cycles, to, gaps);
    step();
    est_lat = 1;
    n_checks++;
    if ((to !== 1'b0) || (cycles !== 70)) begin
      n_fail++;
      $display("FAIL est_delay_cycles: got %0d timed_out %0b expected 70", cycles, to);
    end
    n_checks++;
    if (est_done_cyc - est_start_cyc !== 50) begin
      n_fail++;
      $display("FAIL est_delay_done: got %0d expected 50", est_done_cyc - est_start_cyc);
    end
    n_checks++;
    if (first_req_cyc - est_done_cyc !== 1) begin
      n_fail++;
      $display("FAIL est_delay_req: got %0d expected 1", first_req_cyc - est_done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int s0, d0, w0, n;
    logic found;
    s0 = slot_done_cnt;
    d0 = done_cnt;
    est_lat = 1;
    equ_lat = 1;
    i_num_slots = 4'd3;
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    found = 1'b0;
    n = 0;
    while ((n < 200) && !found) begin
      if ((slot_done_cnt - s0 == 1) && o_equ_start) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    n_checks++;
    if ((found !== 1'b1) || (o_busy !== 1'b1)) begin
      n_fail++;
      $display("FAIL rst_mid_reach: found %0b busy %0b expected 1 1", found, o_busy);
    end
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (all_outs() !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid_immediate: outputs got %h expected 000", all_outs());
    end
    w0 = wen_cnt;
    step();
    step();
    i_rst = 1'b0;
    step();
    step();
    n_checks++;
    if ((all_outs() !== 12'h000) || (wen_cnt - w0 !== 0)) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: outputs %h wen %0d expected 000 0", all_outs(), wen_cnt - w0);
    end
    n_checks++;
    if ((done_cnt - d0 !== 0) || (slot_done_cnt - s0 !== 1)) begin
      n_fail++;
      $display("FAIL rst_mid_pulses: done %0d slot_done %0d expected 0 1",
               done_cnt - d0, slot_done_cnt - s0);
    end
  endtask

  task automatic test_timeout();
`ifdef EQU_SCHED_TIMEOUT_EN
    int d0, n;
    logic found;
    d0 = done_cnt;
    est_lat = 1;
    equ_lat = -1;
    i_num_slots = 4'd1;
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    found = 1'b0;
    n = 0;
    while ((n < 200) && !found) begin
      if (o_timeout) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_seen: o_timeout not seen within budget");
    end
    n_checks++;
    if (timeout_cyc - equ_start_cyc !== 16) begin
      n_fail++;
      $display("FAIL timeout_delay: got %0d expected 16", timeout_cyc - equ_start_cyc);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: busy got %0b expected 0", o_busy);
    end
    step();
    step();
    n_checks++;
    if ((done_cnt - d0 !== 0) || (timeout_cnt !== 1)) begin
      n_fail++;
      $display("FAIL timeout_pulses: done %0d timeouts %0d expected 0 1", done_cnt - d0, timeout_cnt);
    end
    equ_lat = 1;
`else
    n_checks++;
    if (timeout_cnt !== 0) begin
      n_fail++;
      $display("FAIL timeout_tied: got %0d pulses expected 0", timeout_cnt);
    end
`endif
  endtask

  initial begin
    i_rst = 1'b1;
    i_num_slots = 4'd0;
    test_reset();
    test_single("basic", 1'b0);
    test_zero_latency();
    test_multi_slot();
    test_zero_slots();
    test_est_delay();
    test_single("stray", 1'b1);
    test_reset_mid();
    test_single("replay", 1'b0);
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
